// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the register-register issue stage.
// Contents: datapath widths, OP-class opcode and funct constants, the
// issue FSM state encoding, an R-type field layout and a shift helper.
package rv32i_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_AW    = 5;

  localparam logic [6:0] OP_REG  = 7'b0110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // R-type instruction layout, MSB first
  typedef struct packed {
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rs1;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic [6:0]        opcode;
  } rtype_t;

  // Shift ops take only the low five bits of rs2 as the amount
  function automatic logic is_shift(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SRL);
  endfunction

endpackage

// File: rtl/alu_rr_issue_if.sv
// Bundle between the issue stage, its upstream/downstream and debug reader.
// slave : view of alu_rr_issue (accepts instructions, drives alu_base).
// master: view of the environment (upstream, alu_base, debug).
interface alu_rr_issue_if;
  import rv32i_pkg::*;

  logic                    instr_valid;
  logic                    instr_ready;
  logic [XLEN-1:0]         instruction;
  logic                    alu_base_enable;
  logic [2:0]              funct3;
  logic [XLEN-1:0]         rs1_value;
  logic [XLEN-1:0]         rs2_value;
  logic [XLEN-1:0]         alu_rd_value;
  logic                    retire_valid;
  logic [REG_AW-1:0]       retire_rd;
  logic [XLEN-1:0]         retire_value;
  logic                    illegal;
  logic [REG_AW-1:0]       dbg_addr;
  logic [XLEN-1:0]         dbg_data;

  modport slave (
    input  instr_valid, instruction, alu_rd_value, dbg_addr,
    output instr_ready, alu_base_enable, funct3, rs1_value, rs2_value,
           retire_valid, retire_rd, retire_value, illegal, dbg_data
  );

  modport master (
    output instr_valid, instruction, alu_rd_value, dbg_addr,
    input  instr_ready, alu_base_enable, funct3, rs1_value, rs2_value,
           retire_valid, retire_rd, retire_value, illegal, dbg_data
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Architectural register file: x0 hardwired to zero, three combinational
// read ports (two operands + debug), one synchronous write port.
// Ports: clock, reset (async active-high), i_r{a,b,c}_addr -> o_r{a,b,c}_data,
//        i_we/i_wa/i_wd write port (writes to x0 are dropped).
module regfile_2r1w #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  parameter int unsigned AW        = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   i_ra_addr,
  input  logic [AW-1:0]   i_rb_addr,
  input  logic [AW-1:0]   i_rc_addr,
  output logic [XLEN-1:0] o_ra_data,
  output logic [XLEN-1:0] o_rb_data,
  output logic [XLEN-1:0] o_rc_data,
  input  logic            i_we,
  input  logic [AW-1:0]   i_wa,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_regs [REG_COUNT];

  // Write port; entry 0 is never written so it stays at its reset zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) r_regs[i] <= '0;
    end else if (i_we && (i_wa != '0)) begin
      r_regs[i_wa] <= i_wd;
    end
  end

  // Read ports force x0 to zero independent of storage
  assign o_ra_data = (i_ra_addr == '0) ? '0 : r_regs[i_ra_addr];
  assign o_rb_data = (i_rb_addr == '0) ? '0 : r_regs[i_rb_addr];
  assign o_rc_data = (i_rc_addr == '0) ? '0 : r_regs[i_rc_addr];

endmodule

// File: rtl/alu_rr_issue.sv
// Issue/writeback stage for RV32I register-register ops. Accepts one
// instruction in IDLE, reads operands in READ, pulses alu_base for one
// cycle in EXEC, writes the captured result back in WB and retires.
// Ports: clock, reset (async active-high), bus (slave modport: instruction
//        handshake, alu_base drive/result, retire report, debug read).
module alu_rr_issue #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32
) (
  input  logic       clock,
  input  logic       reset,
  alu_rr_issue_if.slave bus
);
  import rv32i_pkg::*;

  localparam int unsigned AW = $clog2(REG_COUNT);

  state_e          r_state, w_next;
  rtype_t          r_inst, w_inst;
  logic            r_ill_pend, w_ill_pend;
  logic            r_ready, w_ready;
  logic            r_en, w_en;
  logic [2:0]      r_f3, w_f3;
  logic [XLEN-1:0] r_rs1, w_rs1;
  logic [XLEN-1:0] r_rs2, w_rs2;
  logic            r_retire, w_retire;
  logic [AW-1:0]   r_rd, w_rd;
  logic [XLEN-1:0] r_rval, w_rval;
  logic            r_ill, w_ill;

  logic [XLEN-1:0] w_ra_data, w_rb_data;
  logic            w_legal;
  logic            w_we;

  assign w_legal = (r_inst.opcode == OP_REG) && (r_inst.funct7 == F7_BASE);
  // Write happens on the WB->IDLE edge, ahead of any following READ
  assign w_we    = (r_state == ST_WB) && !r_ill_pend;

  regfile_2r1w #(
    .XLEN      (XLEN),
    .REG_COUNT (REG_COUNT),
    .AW        (AW)
  ) u_rf (
    .clock     (clock),
    .reset     (reset),
    .i_ra_addr (r_inst.rs1),
    .i_rb_addr (r_inst.rs2),
    .i_rc_addr (bus.dbg_addr),
    .o_ra_data (w_ra_data),
    .o_rb_data (w_rb_data),
    .o_rc_data (bus.dbg_data),
    .i_we      (w_we),
    .i_wa      (r_inst.rd),
    .i_wd      (bus.alu_rd_value)
  );

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_inst     <= '0;
      r_ill_pend <= 1'b0;
      r_ready    <= 1'b1;
      r_en       <= 1'b0;
      r_f3       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_retire   <= 1'b0;
      r_rd       <= '0;
      r_rval     <= '0;
      r_ill      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inst     <= w_inst;
      r_ill_pend <= w_ill_pend;
      r_ready    <= w_ready;
      r_en       <= w_en;
      r_f3       <= w_f3;
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_retire   <= w_retire;
      r_rd       <= w_rd;
      r_rval     <= w_rval;
      r_ill      <= w_ill;
    end
  end

  // Next-state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.instr_valid) w_next = ST_READ;
      ST_READ: w_next = w_legal ? ST_EXEC : ST_WB;
      ST_EXEC: w_next = ST_WB;
      ST_WB:   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and latched fields
  always_comb begin
    w_inst     = r_inst;
    w_ill_pend = r_ill_pend;
    w_f3       = r_f3;
    w_rs1      = r_rs1;
    w_rs2      = r_rs2;
    w_retire   = 1'b0;
    w_rd       = r_rd;
    w_rval     = r_rval;
    w_ill      = r_ill;
    w_ready    = (w_next == ST_IDLE);
    w_en       = (w_next == ST_EXEC);
    case (r_state)
      ST_IDLE: begin
        if (bus.instr_valid) w_inst = rtype_t'(bus.instruction);
      end
      ST_READ: begin
        w_ill_pend = !w_legal;
        if (w_legal) begin
          w_f3  = r_inst.funct3;
          w_rs1 = w_ra_data;
          w_rs2 = is_shift(r_inst.funct3) ?
                  {{(XLEN-5){1'b0}}, w_rb_data[4:0]} : w_rb_data;
        end
      end
      ST_WB: begin
        w_retire = 1'b1;
        w_rd     = r_inst.rd;
        w_ill    = r_ill_pend;
        w_rval   = r_ill_pend ? '0 : bus.alu_rd_value;
      end
      default: ;
    endcase
  end

  assign bus.instr_ready     = r_ready;
  assign bus.alu_base_enable = r_en;
  assign bus.funct3          = r_f3;
  assign bus.rs1_value       = r_rs1;
  assign bus.rs2_value       = r_rs2;
  assign bus.retire_valid    = r_retire;
  assign bus.retire_rd       = r_rd;
  assign bus.retire_value    = r_rval;
  assign bus.illegal         = r_ill;

endmodule
